// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-register clock enables,
// bubble selects, and saturating stall/flush counters for debug readout.
module pipeline_hazard_ctrl #(
  parameter int CntBits     = 16,
  parameter int RegAddrBits = 5
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  input  logic [RegAddrBits-1:0] id_rs1,
  input  logic [RegAddrBits-1:0] id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [RegAddrBits-1:0] ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic                   halt_req,
  input  logic                   resume,
  input  logic                   cnt_clr,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   if_id_bubble,
  output logic                   id_ex_bubble,
  output logic                   mem_wb_bubble,
  output logic                   halted,
  output logic [CntBits-1:0]     stall_cnt,
  output logic [CntBits-1:0]     flush_cnt,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CntBits-1:0] stall_cnt_q, stall_cnt_d;
  logic [CntBits-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use, mem_stall, freeze, resolve, flush_hit, stall_hit, qual;
  logic pc_en_r, if_id_en_r, id_ex_en_r, ex_mem_en_r, mem_wb_en_r;
  logic if_id_bub_r, id_ex_bub_r, mem_wb_bub_r;

  assign load_use = ex_mem_read & (ex_rd != '0) &
                    ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
  assign mem_stall = mem_req & ~mem_ready;

  always_comb begin
    state_d      = state_q;
    freeze       = 1'b0;
    resolve      = 1'b0;
    flush_hit    = 1'b0;
    pc_en_r      = 1'b0;
    if_id_en_r   = 1'b0;
    id_ex_en_r   = 1'b0;
    ex_mem_en_r  = 1'b0;
    mem_wb_en_r  = 1'b0;
    if_id_bub_r  = 1'b0;
    id_ex_bub_r  = 1'b0;
    mem_wb_bub_r = 1'b0;

    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (mem_stall) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          freeze = 1'b1;
        end else begin
          resolve = 1'b1;
          state_d = RUN;
        end
      end
      HALT: begin
        if (resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // Freeze: only MEM/WB advances, taking a bubble while the load is pending.
    if (freeze) begin
      mem_wb_en_r  = 1'b1;
      mem_wb_bub_r = 1'b1;
    end

    // A taken branch squashes the ID instruction, so its load-use is moot.
    if (resolve) begin
      {pc_en_r, if_id_en_r, id_ex_en_r, ex_mem_en_r, mem_wb_en_r} = 5'b11111;
      if (ex_branch_taken) begin
        if_id_bub_r = 1'b1;
        id_ex_bub_r = 1'b1;
        flush_hit   = 1'b1;
      end else if (load_use) begin
        pc_en_r     = 1'b0;
        if_id_en_r  = 1'b0;
        id_ex_bub_r = 1'b1;
      end
    end
  end

  assign qual      = Tick & ~Reset;
  assign stall_hit = ~pc_en_r & (state_q != HALT);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_hit && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_hit && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (Tick) begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_en         = pc_en_r & qual;
  assign if_id_en      = if_id_en_r & qual;
  assign id_ex_en      = id_ex_en_r & qual;
  assign ex_mem_en     = ex_mem_en_r & qual;
  assign mem_wb_en     = mem_wb_en_r & qual;
  assign if_id_bubble  = if_id_bub_r & qual;
  assign id_ex_bubble  = id_ex_bub_r & qual;
  assign mem_wb_bubble = mem_wb_bub_r & qual;
  assign halted        = (state_q == HALT);
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_pipeline_hazard_ctrl;

  logic        Clock = 1'b0;
  logic        Reset, Tick;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic        mem_req, mem_ready, halt_req, resume, cnt_clr;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_bubble, id_ex_bubble, mem_wb_bubble, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  dbg_state;
  logic [4:0]  en_v;
  logic [2:0]  bub_v;

  int pass_cnt = 0;
  int total    = 0;

  always #5 Clock = ~Clock;

  assign en_v  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  assign bub_v = {if_id_bubble, id_ex_bubble, mem_wb_bubble};

  pipeline_hazard_ctrl #(.CntBits(16), .RegAddrBits(5)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .resume(resume),
    .cnt_clr(cnt_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble),
    .mem_wb_bubble(mem_wb_bubble), .halted(halted), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0; halt_req = 0; resume = 0; cnt_clr = 0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
  endtask

  task automatic clear_counters();
    idle_inputs();
    cnt_clr = 1;
    step();
    cnt_clr = 0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (en_v !== 5'b00000) $display("FAIL reset_en got=%b exp=%b", en_v, 5'b00000); else pass_cnt++;
    total++; if (bub_v !== 3'b000) $display("FAIL reset_bub got=%b exp=%b", bub_v, 3'b000); else pass_cnt++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall got=%0d exp=0", stall_cnt); else pass_cnt++;
    total++; if (flush_cnt !== 16'd0) $display("FAIL reset_flush got=%0d exp=0", flush_cnt); else pass_cnt++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else pass_cnt++;
    total++; if (dbg_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else pass_cnt++;
    step();
    Reset = 0;
    #1;
    total++; if (en_v !== 5'b11111) $display("FAIL idle_en got=%b exp=%b", en_v, 5'b11111); else pass_cnt++;
    total++; if (bub_v !== 3'b000) $display("FAIL idle_bub got=%b exp=%b", bub_v, 3'b000); else pass_cnt++;
    step();
  endtask

  task automatic test_load_use();
    set_load_use();
    #1;
    total++; if (en_v !== 5'b00111) $display("FAIL lu_en got=%b exp=%b", en_v, 5'b00111); else pass_cnt++;
    total++; if (bub_v !== 3'b010) $display("FAIL lu_bub got=%b exp=%b", bub_v, 3'b010); else pass_cnt++;
    step();
    idle_inputs();
    #1;
    total++; if (stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); else pass_cnt++;
    total++; if (en_v !== 5'b11111) $display("FAIL lu_after_en got=%b exp=%b", en_v, 5'b11111); else pass_cnt++;
    // Same load shape but writing x0: never a hazard.
    set_load_use();
    ex_rd = 5'd0; id_rs2 = 5'd0;
    #1;
    total++; if (en_v !== 5'b11111) $display("FAIL lu_x0_en got=%b exp=%b", en_v, 5'b11111); else pass_cnt++;
    step();
    // Matching rs1 that the instruction does not read.
    idle_inputs();
    ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 0;
    #1;
    total++; if (en_v !== 5'b11111) $display("FAIL lu_unused_rs1_en got=%b exp=%b", en_v, 5'b11111); else pass_cnt++;
    id_use_rs1 = 1;
    #1;
    total++; if (en_v !== 5'b00111) $display("FAIL lu_rs1_en got=%b exp=%b", en_v, 5'b00111); else pass_cnt++;
    idle_inputs();
    #1;
    total++; if (stall_cnt !== 16'd1) $display("FAIL lu_x0_stall_cnt got=%0d exp=1", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_branch();
    set_load_use();
    ex_branch_taken = 1;
    #1;
    total++; if (en_v !== 5'b11111) $display("FAIL br_en got=%b exp=%b", en_v, 5'b11111); else pass_cnt++;
    total++; if (bub_v !== 3'b110) $display("FAIL br_bub got=%b exp=%b", bub_v, 3'b110); else pass_cnt++;
    step();
    idle_inputs();
    #1;
    total++; if (flush_cnt !== 16'd1) $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt); else pass_cnt++;
    total++; if (stall_cnt !== 16'd1) $display("FAIL br_stall_cnt got=%0d exp=1", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_mem_wait();
    clear_counters();
    mem_req = 1; mem_ready = 1;
    #1;
    total++; if (en_v !== 5'b11111) $display("FAIL mem_1cyc_en got=%b exp=%b", en_v, 5'b11111); else pass_cnt++;
    step();
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (en_v !== 5'b00001) $display("FAIL mem_wait_en[%0d] got=%b exp=%b", i, en_v, 5'b00001); else pass_cnt++;
      total++; if (bub_v !== 3'b001) $display("FAIL mem_wait_bub[%0d] got=%b exp=%b", i, bub_v, 3'b001); else pass_cnt++;
      step();
      total++; if (dbg_state !== 2'd1) $display("FAIL mem_wait_state[%0d] got=%0d exp=1", i, dbg_state); else pass_cnt++;
    end
    mem_ready = 1;
    halt_req = 1;
    #1;
    total++; if (en_v !== 5'b11111) $display("FAIL mem_done_en got=%b exp=%b", en_v, 5'b11111); else pass_cnt++;
    step();
    idle_inputs();
    #1;
    total++; if (dbg_state !== 2'd0) $display("FAIL mem_done_state got=%0d exp=0", dbg_state); else pass_cnt++;
    total++; if (stall_cnt !== 16'd3) $display("FAIL mem_stall_cnt got=%0d exp=3", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_halt();
    clear_counters();
    halt_req = 1;
    #1;
    total++; if (en_v !== 5'b00000) $display("FAIL halt_entry_en got=%b exp=%b", en_v, 5'b00000); else pass_cnt++;
    step();
    halt_req = 0;
    #1;
    total++; if (halted !== 1'b1) $display("FAIL halt_halted got=%b exp=1", halted); else pass_cnt++;
    total++; if (stall_cnt !== 16'd1) $display("FAIL halt_entry_stall got=%0d exp=1", stall_cnt); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin ex_branch_taken = 1; mem_req = 1; end
      #1;
      total++; if (en_v !== 5'b00000) $display("FAIL halt_hold_en[%0d] got=%b exp=%b", i, en_v, 5'b00000); else pass_cnt++;
      step();
    end
    idle_inputs();
    total++; if (stall_cnt !== 16'd1) $display("FAIL halt_hold_stall got=%0d exp=1", stall_cnt); else pass_cnt++;
    total++; if (flush_cnt !== 16'd0) $display("FAIL halt_hold_flush got=%0d exp=0", flush_cnt); else pass_cnt++;
    resume = 1;
    #1;
    total++; if (en_v !== 5'b00000) $display("FAIL resume_en got=%b exp=%b", en_v, 5'b00000); else pass_cnt++;
    step();
    resume = 0;
    #1;
    total++; if (halted !== 1'b0) $display("FAIL resume_halted got=%b exp=0", halted); else pass_cnt++;
    total++; if (en_v !== 5'b11111) $display("FAIL resume_next_en got=%b exp=%b", en_v, 5'b11111); else pass_cnt++;
    total++; if (stall_cnt !== 16'd1) $display("FAIL resume_stall got=%0d exp=1", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_tick_gate();
    clear_counters();
    Tick = 0;
    set_load_use();
    #1;
    total++; if (en_v !== 5'b00000) $display("FAIL tick0_en got=%b exp=%b", en_v, 5'b00000); else pass_cnt++;
    step();
    idle_inputs();
    halt_req = 1;
    step();
    halt_req = 0;
    #1;
    total++; if (stall_cnt !== 16'd0) $display("FAIL tick0_stall got=%0d exp=0", stall_cnt); else pass_cnt++;
    total++; if (dbg_state !== 2'd0) $display("FAIL tick0_state got=%0d exp=0", dbg_state); else pass_cnt++;
    Tick = 1;
    #1;
    total++; if (en_v !== 5'b11111) $display("FAIL tick1_en got=%b exp=%b", en_v, 5'b11111); else pass_cnt++;
  endtask

  task automatic test_saturation();
    clear_counters();
    set_load_use();
    repeat (65537) step();
    #1;
    total++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_stall got=%h exp=ffff", stall_cnt); else pass_cnt++;
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    idle_inputs();
    #1;
    total++; if (stall_cnt !== 16'd0) $display("FAIL clr_over_stall got=%h exp=0000", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    ex_branch_taken = 1;
    step();
    idle_inputs();
    mem_req = 1; mem_ready = 0;
    step();
    total++; if (dbg_state !== 2'd1) $display("FAIL arst_pre_state got=%0d exp=1", dbg_state); else pass_cnt++;
    #2;
    Reset = 1;
    #1;
    total++; if (en_v !== 5'b00000) $display("FAIL arst_en got=%b exp=%b", en_v, 5'b00000); else pass_cnt++;
    total++; if (dbg_state !== 2'd0) $display("FAIL arst_state got=%0d exp=0", dbg_state); else pass_cnt++;
    total++; if (flush_cnt !== 16'd0) $display("FAIL arst_flush got=%0d exp=0", flush_cnt); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      Tick = ~Tick;
      step();
    end
    Tick = 1;
    idle_inputs();
    Reset = 0;
    #1;
    total++; if (en_v !== 5'b11111) $display("FAIL arst_after_en got=%b exp=%b", en_v, 5'b11111); else pass_cnt++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL arst_after_stall got=%0d exp=0", stall_cnt); else pass_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1;
    Tick  = 1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_halt();
    test_tick_gate();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
